ext_obi_demux: RTL

EXT_OBI_DEMUX -- requirements
Module: ext_obi_demux

---
 rtl/addr_map_rule_pkg.sv | 8 +
 rtl/ext_obi_demux_pkg.sv | 22 ++
 rtl/ext_obi_err_slave.sv | 21 ++
 rtl/ext_obi_demux.sv | 126 ++++++++++++
 4 files changed

// File: rtl/addr_map_rule_pkg.sv
// Address-map rule type shared by interconnect decoders.
package addr_map_rule_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;
endpackage

// File: rtl/ext_obi_demux_pkg.sv
// Testharness-side constants for the external OBI slave demux: slave indices,
// default address windows and the error-response data word.
package ext_obi_demux_pkg;
  import addr_map_rule_pkg::*;

  localparam int          EXT_NSLAVE              = 2;
  localparam logic [31:0] EXT_SLAVE_START_ADDRESS = 32'h2000_0000;
  localparam logic [31:0] EXT_SLAVE_SIZE          = 32'h0000_0100;
  localparam logic [31:0] EXT_SLAVE0_IDX          = 32'd0;
  localparam logic [31:0] EXT_SLAVE1_IDX          = 32'd1;
  localparam logic [31:0] EXT_ERR_RDATA           = 32'hBADC_AB1E;

  // Two contiguous windows; end addresses are exclusive.
  localparam addr_map_rule_t [EXT_NSLAVE-1:0] EXT_DEFAULT_RULES = {
    addr_map_rule_t'{idx:        EXT_SLAVE1_IDX,
                     start_addr: EXT_SLAVE_START_ADDRESS + EXT_SLAVE_SIZE,
                     end_addr:   EXT_SLAVE_START_ADDRESS + (EXT_SLAVE_SIZE << 1)},
    addr_map_rule_t'{idx:        EXT_SLAVE0_IDX,
                     start_addr: EXT_SLAVE_START_ADDRESS,
                     end_addr:   EXT_SLAVE_START_ADDRESS + EXT_SLAVE_SIZE}
  };
endpackage

// File: rtl/ext_obi_err_slave.sv
// Error target: answers every granted request one cycle later with the
// error data word.
module ext_obi_err_slave
  import ext_obi_demux_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);
  logic r_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_vld <= 1'b0;
    else         r_vld <= req_i;
  end

  assign rvalid_o = r_vld;
  assign rdata_o  = r_vld ? EXT_ERR_RDATA : '0;
endmodule

// File: rtl/ext_obi_demux.sv
// One-master to NSLAVE OBI demux with in-order response tracking.
// EXT_OBI_DEMUX_ERR_RESP_EN: unmapped addresses go to an internal error slave
// (err_o, decode_err_cnt_o); otherwise they are routed to slave 0.
module ext_obi_demux
  import addr_map_rule_pkg::*;
  import ext_obi_demux_pkg::*;
#(
  parameter int                          NSLAVE          = EXT_NSLAVE,
  parameter int                          MAX_OUTSTANDING = 4,
  parameter addr_map_rule_t [NSLAVE-1:0] ADDR_RULES      = EXT_DEFAULT_RULES
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic [31:0]            addr_i,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            wdata_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic [NSLAVE-1:0]      slv_req_o,
  output logic [31:0]            slv_addr_o,
  output logic [31:0]            slv_wdata_o,
  output logic                   slv_we_o,
  output logic [3:0]             slv_be_o,
  input  logic [NSLAVE-1:0]      slv_gnt_i,
  input  logic [NSLAVE-1:0]      slv_rvalid_i,
  input  logic [NSLAVE-1:0][31:0] slv_rdata_i,
  output logic [15:0]            decode_err_cnt_o
);
  localparam int TW = $clog2(NSLAVE + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_last;
  logic [TW-1:0] w_tgt;
  logic          w_allow, w_is_err, w_sgnt, w_gnt;
  logic          w_srv, w_rvalid, w_err_rv;
  logic [31:0]   w_srdata, w_err_rdata;

  // Lowest-numbered matching rule wins, so scan downward and let later hits override.
  always_comb begin
`ifdef EXT_OBI_DEMUX_ERR_RESP_EN
    w_tgt = TW'(NSLAVE);
`else
    w_tgt = '0;
`endif
    for (int i = NSLAVE - 1; i >= 0; i--)
      if (addr_i >= ADDR_RULES[i].start_addr && addr_i < ADDR_RULES[i].end_addr)
        w_tgt = ADDR_RULES[i].idx[TW-1:0];
  end

  // Mixing targets while responses are pending could reorder them, so only
  // the last target may be issued to until the pipe drains.
  assign w_allow = (r_cnt < CW'(MAX_OUTSTANDING)) && (r_cnt == '0 || w_tgt == r_last);

  always_comb begin
    w_sgnt    = 1'b0;
    w_srv     = 1'b0;
    w_srdata  = '0;
    slv_req_o = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      slv_req_o[i] = rst_ni && w_allow && req_i && (w_tgt == TW'(i));
      if (w_tgt == TW'(i)) w_sgnt = slv_gnt_i[i];
      if (r_last == TW'(i)) begin
        w_srv    = slv_rvalid_i[i];
        w_srdata = slv_rdata_i[i];
      end
    end
  end

`ifdef EXT_OBI_DEMUX_ERR_RESP_EN
  logic [15:0] r_dec_cnt;

  assign w_is_err = (w_tgt == TW'(NSLAVE));

  ext_obi_err_slave u_err_slave (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (w_gnt && w_is_err),
    .rvalid_o (w_err_rv),
    .rdata_o  (w_err_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_dec_cnt <= '0;
    else if (w_gnt && w_is_err && r_dec_cnt != 16'hFFFF)
      r_dec_cnt <= r_dec_cnt + 16'd1;
  end

  assign decode_err_cnt_o = r_dec_cnt;
  assign err_o            = rst_ni && w_err_rv;
`else
  assign w_is_err         = 1'b0;
  assign w_err_rv         = 1'b0;
  assign w_err_rdata      = '0;
  assign decode_err_cnt_o = '0;
  assign err_o            = 1'b0;
`endif

  assign w_gnt    = rst_ni && w_allow && req_i && (w_is_err || w_sgnt);
  assign w_rvalid = rst_ni && (w_err_rv || (w_srv && r_cnt != '0));

  assign gnt_o    = w_gnt;
  assign rvalid_o = w_rvalid;
  assign rdata_o  = !w_rvalid ? '0 : (w_err_rv ? w_err_rdata : w_srdata);

  assign slv_addr_o  = addr_i;
  assign slv_wdata_o = wdata_i;
  assign slv_we_o    = we_i;
  assign slv_be_o    = be_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      if (w_gnt) r_last <= w_tgt;
      if (w_gnt && !w_rvalid)      r_cnt <= r_cnt + 1'b1;
      else if (!w_gnt && w_rvalid) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule
